alu_req_arbiter: RTL and testbench

- Sequences and shares a single 8-bit combinational ALU (InputA/InputB/OpCode -> OutALU[15:0]) between two requesters.
- Each requester issues operand/opcode requests on a valid/ready channel and receives the 16-bit result on a valid/ready response channel.
- The block registers the ALU operands, waits a programmable settle time, captures OutALU, and returns the result to the requester that issued the request.
- It sits between the requesting datapath blocks and the ALU instance.

---
 rtl/alu_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one combinational 8-bit ALU between two requesters. A request
//   (operands + opcode) is accepted on a valid/ready channel, its operands
//   are registered onto the ALU inputs and held for SETTLE_CYCLES cycles,
//   then AluOut is captured and returned on the owning requester's
//   valid/ready response channel.
//
// Ports
//   Clk, Reset            : clock (rising edge), synchronous active-high reset
//   ReqnValid/ReqnReady   : request handshake for requester n (n = 0, 1)
//   ReqnA/ReqnB/ReqnOp    : operands and opcode for requester n
//   RspnValid/RspnReady   : response handshake for requester n
//   RspnData              : 16-bit result for requester n (0 when not owner)
//   AluA/AluB/AluOp       : registered drive to the ALU inputs
//   AluOut                : ALU result
//   Busy                  : high whenever the arbiter is not idle
//   GrantId               : requester owning the current operation

module alu_req_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,

  input  logic        Req0Valid,
  output logic        Req0Ready,
  input  logic [7:0]  Req0A,
  input  logic [7:0]  Req0B,
  input  logic [2:0]  Req0Op,

  input  logic        Req1Valid,
  output logic        Req1Ready,
  input  logic [7:0]  Req1A,
  input  logic [7:0]  Req1B,
  input  logic [2:0]  Req1Op,

  output logic        Rsp0Valid,
  input  logic        Rsp0Ready,
  output logic [15:0] Rsp0Data,

  output logic        Rsp1Valid,
  input  logic        Rsp1Ready,
  output logic [15:0] Rsp1Data,

  output logic [7:0]  AluA,
  output logic [7:0]  AluB,
  output logic [2:0]  AluOp,
  input  logic [15:0] AluOut,

  output logic        Busy,
  output logic        GrantId
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_req_arbiter: SETTLE_CYCLES must be >= 1");
  end

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;
  logic [CW-1:0]   settle_cnt;
  logic [15:0]     result;
  logic            winner;
  logic            owner_rsp_ready;

  // Round robin: a lone requester wins outright; on a tie the requester
  // that did not win last time goes first.
  always_comb begin
    winner = 1'b0;
    if (Req0Valid && Req1Valid) begin
      winner = ~last_grant;
    end else if (Req1Valid) begin
      winner = 1'b1;
    end
  end

  // Ready is suppressed while Reset is asserted so nothing looks accepted
  // on the reset edge.
  assign Req0Ready = ~Reset && (state == IDLE) && Req0Valid && !winner;
  assign Req1Ready = ~Reset && (state == IDLE) && Req1Valid &&  winner;

  assign Rsp0Valid = (state == RESP) && !GrantId;
  assign Rsp1Valid = (state == RESP) &&  GrantId;
  assign Rsp0Data  = Rsp0Valid ? result : '0;
  assign Rsp1Data  = Rsp1Valid ? result : '0;

  // Only the owner's RspReady can complete the response.
  assign owner_rsp_ready = GrantId ? Rsp1Ready : Rsp0Ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      AluA       <= '0;
      AluB       <= '0;
      AluOp      <= '0;
      result     <= '0;
      GrantId    <= 1'b0;
      last_grant <= 1'b1;
      settle_cnt <= '0;
      Busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req0Ready) begin
            AluA       <= Req0A;
            AluB       <= Req0B;
            AluOp      <= Req0Op;
            GrantId    <= 1'b0;
            last_grant <= 1'b0;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
            Busy       <= 1'b1;
          end else if (Req1Ready) begin
            AluA       <= Req1A;
            AluB       <= Req1B;
            AluOp      <= Req1Op;
            GrantId    <= 1'b1;
            last_grant <= 1'b1;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
            Busy       <= 1'b1;
          end
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            result <= AluOut;
            state  <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        RESP: begin
          if (owner_rsp_ready) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
//   Directed bench for alu_req_arbiter. One instance runs with
//   SETTLE_CYCLES=1 and a second with SETTLE_CYCLES=3; each drives a small
//   behavioural ALU (000 add, 001 sub, 010 mul, 011 or, 100 shl1, 101 and,
//   110 not A, 111 xor).

module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    logic [15:0] r;
    case (op)
      3'b000: r = {8'h00, a} + {8'h00, b};
      3'b001: r = {8'h00, a} - {8'h00, b};
      3'b010: r = {8'h00, a} * {8'h00, b};
      3'b011: r = {8'h00, a | b};
      3'b100: r = {7'h00, a, 1'b0};
      3'b101: r = {8'h00, a & b};
      3'b110: r = {8'h00, ~a};
      default: r = {8'h00, a ^ b};
    endcase
    return r;
  endfunction

  // SETTLE_CYCLES = 1 instance
  logic        reset;
  logic        r0v, r1v, q0r, q1r;
  logic [7:0]  r0a, r0b, r1a, r1b;
  logic [2:0]  r0op, r1op;
  logic        s0v, s1v, rs0r, rs1r;
  logic [15:0] s0d, s1d;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic        busy, gid;

  assign alu_out = alu_model(alu_a, alu_b, alu_op);

  alu_req_arbiter #(.SETTLE_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(reset),
    .Req0Valid(r0v), .Req0Ready(q0r), .Req0A(r0a), .Req0B(r0b), .Req0Op(r0op),
    .Req1Valid(r1v), .Req1Ready(q1r), .Req1A(r1a), .Req1B(r1b), .Req1Op(r1op),
    .Rsp0Valid(s0v), .Rsp0Ready(rs0r), .Rsp0Data(s0d),
    .Rsp1Valid(s1v), .Rsp1Ready(rs1r), .Rsp1Data(s1d),
    .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .AluOut(alu_out),
    .Busy(busy), .GrantId(gid)
  );

  // SETTLE_CYCLES = 3 instance
  logic        c_reset;
  logic        c_r0v, c_r1v, c_q0r, c_q1r;
  logic [7:0]  c_r0a, c_r0b, c_r1a, c_r1b;
  logic [2:0]  c_r0op, c_r1op;
  logic        c_s0v, c_s1v, c_rs0r, c_rs1r;
  logic [15:0] c_s0d, c_s1d;
  logic [7:0]  c_alu_a, c_alu_b;
  logic [2:0]  c_alu_op;
  logic [15:0] c_alu_out;
  logic        c_busy, c_gid;

  assign c_alu_out = alu_model(c_alu_a, c_alu_b, c_alu_op);

  alu_req_arbiter #(.SETTLE_CYCLES(3)) dut3 (
    .Clk(clk), .Reset(c_reset),
    .Req0Valid(c_r0v), .Req0Ready(c_q0r), .Req0A(c_r0a), .Req0B(c_r0b), .Req0Op(c_r0op),
    .Req1Valid(c_r1v), .Req1Ready(c_q1r), .Req1A(c_r1a), .Req1B(c_r1b), .Req1Op(c_r1op),
    .Rsp0Valid(c_s0v), .Rsp0Ready(c_rs0r), .Rsp0Data(c_s0d),
    .Rsp1Valid(c_s1v), .Rsp1Ready(c_rs1r), .Rsp1Data(c_s1d),
    .AluA(c_alu_a), .AluB(c_alu_b), .AluOp(c_alu_op), .AluOut(c_alu_out),
    .Busy(c_busy), .GrantId(c_gid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    r0v = 0; r1v = 0; r0a = 0; r0b = 0; r0op = 0; r1a = 0; r1b = 0; r1op = 0;
    rs0r = 0; rs1r = 0;
    c_reset = 1'b1;
    c_r0v = 0; c_r1v = 0; c_r0a = 0; c_r0b = 0; c_r0op = 0;
    c_r1a = 0; c_r1b = 0; c_r1op = 0; c_rs0r = 0; c_rs1r = 0;

    // ---------------- reset state ----------------
    tick(); tick();
    r0v = 1; r0a = 8'h0F; r0b = 8'h03; r0op = 3'b000;
    #1;
    chk("rst_req0_ready", 16'(q0r), 16'd0);
    chk("rst_req1_ready", 16'(q1r), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_grant", 16'(gid), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_op", 16'(alu_op), 16'd0);
    chk("rst_rsp0_valid", 16'(s0v), 16'd0);
    chk("rst_rsp1_valid", 16'(s1v), 16'd0);

    // ---------------- single op: 0x0F + 0x03 ----------------
    reset = 0;
    #1;
    chk("t1_req0_ready", 16'(q0r), 16'd1);
    chk("t1_req1_ready", 16'(q1r), 16'd0);
    tick();                                   // accept edge
    r0v = 0;
    #1;
    chk("t1_busy", 16'(busy), 16'd1);
    chk("t1_grant", 16'(gid), 16'd0);
    chk("t1_alu_a", 16'(alu_a), 16'h000F);
    chk("t1_alu_b", 16'(alu_b), 16'h0003);
    chk("t1_alu_op", 16'(alu_op), 16'd0);
    chk("t1_rsp0_early", 16'(s0v), 16'd0);
    tick();                                   // capture edge
    chk("t1_rsp0_valid", 16'(s0v), 16'd1);
    chk("t1_rsp0_data", s0d, 16'h0012);
    chk("t1_rsp1_valid", 16'(s1v), 16'd0);
    chk("t1_rsp1_data", s1d, 16'h0000);
    tick();
    chk("t1_rsp0_hold", 16'(s0v), 16'd1);
    chk("t1_rsp0_hold_data", s0d, 16'h0012);
    rs0r = 1;
    tick();                                   // handshake edge
    rs0r = 0;
    chk("t1_rsp0_done", 16'(s0v), 16'd0);
    chk("t1_busy_done", 16'(busy), 16'd0);
    chk("t1_alu_a_retained", 16'(alu_a), 16'h000F);

    // ---------------- tie after reset ----------------
    reset = 1;
    tick();
    reset = 0;
    r0v = 1; r0a = 8'h0F; r0b = 8'h03; r0op = 3'b010;
    r1v = 1; r1a = 8'h0F; r1b = 8'h03; r1op = 3'b111;
    #1;
    chk("t2_req0_ready", 16'(q0r), 16'd1);
    chk("t2_req1_ready", 16'(q1r), 16'd0);
    tick();
    r0v = 0;
    #1;
    chk("t2_grant0", 16'(gid), 16'd0);
    chk("t2_req1_wait", 16'(q1r), 16'd0);
    tick();
    chk("t2_rsp0_valid", 16'(s0v), 16'd1);
    chk("t2_rsp0_data", s0d, 16'h002D);
    chk("t2_req1_in_resp", 16'(q1r), 16'd0);
    rs0r = 1;
    tick();
    rs0r = 0;
    #1;
    chk("t2_rsp0_done", 16'(s0v), 16'd0);
    chk("t2_req1_ready", 16'(q1r), 16'd1);
    tick();
    r1v = 0;
    #1;
    chk("t2_grant1", 16'(gid), 16'd1);
    chk("t2_alu_op", 16'(alu_op), 16'd7);
    tick();
    chk("t2_rsp1_valid", 16'(s1v), 16'd1);
    chk("t2_rsp1_data", s1d, 16'h000C);
    chk("t2_rsp0_quiet", 16'(s0v), 16'd0);
    rs0r = 1;                                 // non-owner ready is ignored
    tick();
    rs0r = 0;
    chk("t2_nonowner_ignored", 16'(s1v), 16'd1);
    rs1r = 1;
    tick();
    rs1r = 0;
    chk("t2_rsp1_done", 16'(s1v), 16'd0);

    // ---------------- fairness ----------------
    r0v = 1; r0a = 8'h05; r0b = 8'h02; r0op = 3'b000;
    r1v = 1; r1a = 8'h09; r1b = 8'h04; r1op = 3'b001;
    rs0r = 1; rs1r = 1;
    #1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 12 && !(q0r || q1r); k++) tick();
      chk("fair_ready", 16'(q0r | q1r), 16'd1);
      chk("fair_winner", 16'(q1r), 16'(i % 2));
      tick();
      chk("fair_grant", 16'(gid), 16'(i % 2));
    end
    r0v = 0; r1v = 0;
    tick(); tick(); tick();
    chk("fair_idle", 16'(busy), 16'd0);
    rs0r = 0; rs1r = 0;

    // ---------------- response backpressure ----------------
    r1v = 1; r1a = 8'h0F; r1b = 8'h03; r1op = 3'b101;
    #1;
    chk("bp_req1_ready", 16'(q1r), 16'd1);
    tick();
    r1v = 0;
    r0v = 1; r0a = 8'h0F; r0b = 8'h03; r0op = 3'b010;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp1_valid", 16'(s1v), 16'd1);
      chk("bp_rsp1_data", s1d, 16'h0003);
      chk("bp_req0_blocked", 16'(q0r), 16'd0);
      chk("bp_busy", 16'(busy), 16'd1);
      tick();
    end
    rs1r = 1;
    tick();
    rs1r = 0;
    chk("bp_rsp1_done", 16'(s1v), 16'd0);
    chk("bp_req0_ready", 16'(q0r), 16'd1);

    // ---------------- reset during SETTLE ----------------
    tick();                                   // req0 accepted, now SETTLE
    r0v = 0;
    chk("mid_busy", 16'(busy), 16'd1);
    reset = 1;
    tick();
    chk("mid_busy_cleared", 16'(busy), 16'd0);
    chk("mid_grant", 16'(gid), 16'd0);
    chk("mid_alu_a", 16'(alu_a), 16'd0);
    chk("mid_alu_b", 16'(alu_b), 16'd0);
    chk("mid_alu_op", 16'(alu_op), 16'd0);
    chk("mid_rsp0", 16'(s0v), 16'd0);
    chk("mid_rsp1", 16'(s1v), 16'd0);
    reset = 0;
    tick();
    chk("mid_no_rsp0", 16'(s0v), 16'd0);
    chk("mid_no_busy", 16'(busy), 16'd0);
    r1v = 1; r1a = 8'h12; r1b = 8'h34; r1op = 3'b000;
    #1;
    chk("mid_req1_ready", 16'(q1r), 16'd1);
    tick();
    r1v = 0;
    tick();
    chk("mid_rsp1_valid", 16'(s1v), 16'd1);
    chk("mid_rsp1_data", s1d, 16'h0046);
    rs1r = 1;
    tick();
    rs1r = 0;

    // ---------------- SETTLE_CYCLES = 3 ----------------
    c_reset = 0;
    c_r0v = 1; c_r0a = 8'hAB; c_r0b = 8'h02; c_r0op = 3'b011;
    #1;
    chk("s3_req0_ready", 16'(c_q0r), 16'd1);
    tick();                                   // accept edge
    c_r0v = 0;
    for (int k = 0; k < 3; k++) begin
      chk("s3_alu_a", 16'(c_alu_a), 16'h00AB);
      chk("s3_alu_b", 16'(c_alu_b), 16'h0002);
      chk("s3_alu_op", 16'(c_alu_op), 16'd3);
      chk("s3_rsp0_early", 16'(c_s0v), 16'd0);
      tick();
    end
    chk("s3_rsp0_valid", 16'(c_s0v), 16'd1);
    chk("s3_rsp0_data", c_s0d, 16'h00AB);
    c_rs0r = 1;
    tick();
    c_rs0r = 0;
    chk("s3_done", 16'(c_busy), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
